// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared op codes, FSM state codes and iteration count for the
//            HI/LO multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam int unsigned c_data_w = 32;
    localparam logic [5:0]  c_iters  = 6'd32;

    localparam logic [1:0] c_op_mult  = 2'b00;
    localparam logic [1:0] c_op_multu = 2'b01;
    localparam logic [1:0] c_op_div   = 2'b10;
    localparam logic [1:0] c_op_divu  = 2'b11;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    function automatic logic f_is_signed(input logic [1:0] op);
        return (op == c_op_mult) || (op == c_op_div);
    endfunction

    function automatic logic f_is_div(input logic [1:0] op);
        return !((op == c_op_mult) || (op == c_op_multu));
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_iter.sv
// ============================================================================
// Module   : div_iter
// Brief    : Unsigned restoring divider, one quotient bit per step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_iter
    import muldiv_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_step,
    input  logic [c_data_w-1:0] i_dividend,
    input  logic [c_data_w-1:0] i_divisor,
    output logic [c_data_w-1:0] o_quotient,
    output logic [c_data_w-1:0] o_remainder
);

    logic [c_data_w-1:0] r_divisor;
    logic [c_data_w-1:0] r_quo;
    logic [c_data_w-1:0] r_rem;
    logic [c_data_w:0]   w_shift;
    logic [c_data_w:0]   w_diff;

    // Remainder stays below the divisor, so bit c_data_w of the trial
    // difference is a clean borrow flag.
    assign w_shift = {r_rem, r_quo[c_data_w-1]};
    assign w_diff  = w_shift - {1'b0, r_divisor};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_divisor <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
        end else if (i_load) begin
            r_divisor <= i_divisor;
            r_quo     <= i_dividend;
            r_rem     <= '0;
        end else if (i_step) begin
            if (!w_diff[c_data_w]) begin
                r_rem <= w_diff[c_data_w-1:0];
                r_quo <= {r_quo[c_data_w-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[c_data_w-1:0];
                r_quo <= {r_quo[c_data_w-2:0], 1'b0};
            end
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

`default_nettype wire

// File: rtl/hilo_muldiv.sv
// ============================================================================
// Module   : hilo_muldiv
// Brief    : Iterative MULT/MULTU/DIV/DIVU unit writing the HI/LO registers.
//            Macro MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall_req,
    output logic             done,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_wdata,
    output logic [WIDTH-1:0] lo_wdata
);

    logic [1:0]         r_state;
    logic [1:0]         r_op;
    logic [5:0]         r_cnt;
    logic [WIDTH-1:0]   r_src_a;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               r_b_zero;

    logic               w_signed;
    logic               w_accept;
    logic               w_last;
    logic               w_done;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_signed = f_is_signed(op);
    assign w_mag_a  = (w_signed && src_a[WIDTH-1]) ? (~src_a + 1'b1) : src_a;
    assign w_mag_b  = (w_signed && src_b[WIDTH-1]) ? (~src_b + 1'b1) : src_b;
    assign w_accept = (r_state == c_st_idle) && start && !flush;
    assign w_last   = (r_cnt == c_iters - 6'd1);

    assign w_mul_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                     + (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_op     <= '0;
            r_cnt    <= '0;
            r_src_a  <= '0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_b_zero <= 1'b0;
        end else if (flush) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_op     <= op;
                        r_cnt    <= '0;
                        r_src_a  <= src_a;
                        r_mcand  <= w_mag_b;
                        r_b_zero <= (src_b == '0);
                        // Quotient/product sign from both operands; remainder follows the dividend.
                        r_neg_lo <= w_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        r_neg_hi <= w_signed && (f_is_div(op) ? src_a[WIDTH-1]
                                                              : (src_a[WIDTH-1] ^ src_b[WIDTH-1]));
`ifdef MULDIV_FAST_MUL_EN
                        r_prod  <= {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
                        r_state <= f_is_div(op) ? c_st_div : c_st_done;
`else
                        r_prod  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_state <= f_is_div(op) ? c_st_div : c_st_mul;
`endif
                    end
                end
                c_st_mul: begin
                    r_prod <= {w_mul_sum, r_prod[WIDTH-1:1]};
                    r_cnt  <= r_cnt + 6'd1;
                    if (w_last) r_state <= c_st_done;
                end
                c_st_div: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (w_last) r_state <= c_st_done;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    div_iter u_div_iter (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept && f_is_div(op)),
        .i_step      ((r_state == c_st_div) && !flush),
        .i_dividend  (w_mag_a),
        .i_divisor   (w_mag_b),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    assign w_prod_fix = r_neg_lo ? (~r_prod + 1'b1) : r_prod;
    assign w_quo_fix  = r_neg_lo ? (~w_quo + 1'b1) : w_quo;
    assign w_rem_fix  = r_neg_hi ? (~w_rem + 1'b1) : w_rem;

    assign w_done    = (r_state == c_st_done) && !flush && !rst;
    assign done      = w_done;
    assign hi_we     = w_done;
    assign lo_we     = w_done;
    assign stall_req = !rst && (((r_state == c_st_idle) && start)
                                || (r_state == c_st_mul) || (r_state == c_st_div));

    always_comb begin
        hi_wdata = '0;
        lo_wdata = '0;
        if (w_done) begin
            if (f_is_div(r_op)) begin
                if (r_b_zero) begin
                    lo_wdata = {WIDTH{1'b1}};
                    hi_wdata = r_src_a;
                end else begin
                    lo_wdata = w_quo_fix;
                    hi_wdata = w_rem_fix;
                end
            end else begin
                lo_wdata = w_prod_fix[WIDTH-1:0];
                hi_wdata = w_prod_fix[2*WIDTH-1:WIDTH];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv.sv
// ============================================================================
// Module   : tb_hilo_muldiv
// Brief    : Directed self-checking bench for hilo_muldiv; honours
//            MULDIV_FAST_MUL_EN for multiply latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`define CHECK(TAG, OBS, EXP) \
    begin \
        checks++; \
        assert ((OBS) === (EXP)) else begin \
            errors++; \
            $error("FAIL %s: observed %0h expected %0h", TAG, (OBS), (EXP)); \
        end \
    end

module tb_hilo_muldiv;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT       = 1;
    localparam int RESTART_DONES = 2;
`else
    localparam int MUL_LAT       = 33;
    localparam int RESTART_DONES = 1;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_req;
    logic        done;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    int          checks = 0;
    int          errors = 0;

    int          t_done_cnt;
    int          t_we_cnt;
    int          t_done_cyc;
    int          t_stall_cnt;
    int          t_bad;
    logic [31:0] t_hi;
    logic [31:0] t_lo;
    logic [63:0] t_stall;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .stall_req (stall_req),
        .done      (done),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .hi_wdata  (hi_wdata),
        .lo_wdata  (lo_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Cycle 0 presents the start; cycle k is the period ending at rising edge k.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] a2, input logic [31:0] b2,
                          input int flush_at, input int restart_at, input int rst_at,
                          input int ncycles);
        t_done_cnt  = 0;
        t_we_cnt    = 0;
        t_done_cyc  = -1;
        t_stall_cnt = 0;
        t_bad       = 0;
        t_hi        = '0;
        t_lo        = '0;
        t_stall     = '0;
        @(negedge clk);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        #1;
        t_stall[0] = stall_req;
        if (stall_req) t_stall_cnt++;
        for (int k = 1; k <= ncycles; k++) begin
            @(negedge clk);
            start = (k == restart_at);
            flush = (k == flush_at);
            rst   = (k == rst_at);
            if (k == restart_at) begin
                src_a = a2;
                src_b = b2;
            end
            #1;
            if (k < 64) t_stall[k] = stall_req;
            if (stall_req) t_stall_cnt++;
            if (hi_we || lo_we) t_we_cnt++;
            if ((hi_we !== done) || (lo_we !== done)) t_bad++;
            if (!done && ((hi_wdata != 32'h0) || (lo_wdata != 32'h0))) t_bad++;
            if (done) begin
                t_done_cnt++;
                if (t_done_cyc < 0) begin
                    t_done_cyc = k;
                    t_hi       = hi_wdata;
                    t_lo       = lo_wdata;
                end
            end
        end
        start = 1'b0;
        flush = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        src_a = '0;
        src_b = '0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        src_a = 32'h1234;
        src_b = 32'h5;
        #1;
        `CHECK("rst_stall", stall_req, 1'b0)
        `CHECK("rst_done", done, 1'b0)
        `CHECK("rst_hi_we", hi_we, 1'b0)
        `CHECK("rst_lo_we", lo_we, 1'b0)
        `CHECK("rst_hi_wdata", hi_wdata, 32'h0)
        `CHECK("rst_lo_wdata", lo_wdata, 32'h0)
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;

        // MULTU all-ones squared
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 0, 0, 36);
        `CHECK("multu_hi", t_hi, 32'hFFFF_FFFE)
        `CHECK("multu_lo", t_lo, 32'h0000_0001)
        `CHECK("multu_done_cycle", t_done_cyc, MUL_LAT)
        `CHECK("multu_done_count", t_done_cnt, 1)
        `CHECK("multu_stall_c0", t_stall[0], 1'b1)
        `CHECK("multu_stall_done", t_stall[MUL_LAT], 1'b0)
        `CHECK("multu_outputs", t_bad, 0)

        // MULT -3 * 5 = -15
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0, 32'h0, 0, 0, 0, 36);
        `CHECK("mult_neg_hi", t_hi, 32'hFFFF_FFFF)
        `CHECK("mult_neg_lo", t_lo, 32'hFFFF_FFF1)

        // MULT (2^31-1) * (-2^31)
        run_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 36);
        `CHECK("mult_ext_hi", t_hi, 32'hC000_0000)
        `CHECK("mult_ext_lo", t_lo, 32'h8000_0000)

        // DIV -7 / 2
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0, 32'h0, 0, 0, 0, 36);
        `CHECK("div_m7_lo", t_lo, 32'hFFFF_FFFD)
        `CHECK("div_m7_hi", t_hi, 32'hFFFF_FFFF)
        `CHECK("div_m7_done_cycle", t_done_cyc, 33)
        `CHECK("div_m7_stall_c32", t_stall[32], 1'b1)
        `CHECK("div_m7_stall_c33", t_stall[33], 1'b0)
        `CHECK("div_m7_stall_count", t_stall_cnt, 33)
        `CHECK("div_m7_outputs", t_bad, 0)

        // DIVU 100 / 0
        run_op(2'b11, 32'd100, 32'd0, 32'h0, 32'h0, 0, 0, 0, 36);
        `CHECK("divu_zero_lo", t_lo, 32'hFFFF_FFFF)
        `CHECK("divu_zero_hi", t_hi, 32'd100)
        `CHECK("divu_zero_done_cycle", t_done_cyc, 33)

        // DIV -5 / 0
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 32'h0, 32'h0, 0, 0, 0, 36);
        `CHECK("div_zero_lo", t_lo, 32'hFFFF_FFFF)
        `CHECK("div_zero_hi", t_hi, 32'hFFFF_FFFB)

        // DIV overflow case
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 0, 0, 36);
        `CHECK("div_ovf_lo", t_lo, 32'h8000_0000)
        `CHECK("div_ovf_hi", t_hi, 32'h0000_0000)

        // DIVU all-ones / 16 and DIV 7 / -2
        run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0, 32'h0, 0, 0, 0, 36);
        `CHECK("divu_lo", t_lo, 32'h0FFF_FFFF)
        `CHECK("divu_hi", t_hi, 32'h0000_000F)
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0, 32'h0, 0, 0, 0, 36);
        `CHECK("div_7_lo", t_lo, 32'hFFFF_FFFD)
        `CHECK("div_7_hi", t_hi, 32'h0000_0001)

        // Flush a DIVU in cycle 10, restart 100 / 7 in cycle 11
        run_op(2'b11, 32'd1000, 32'd3, 32'd100, 32'd7, 10, 11, 0, 50);
        `CHECK("flush_stall_c11", t_stall[11], 1'b1)
        `CHECK("flush_done_count", t_done_cnt, 1)
        `CHECK("flush_we_count", t_we_cnt, 1)
        `CHECK("flush_done_cycle", t_done_cyc, 44)
        `CHECK("flush_restart_lo", t_lo, 32'd14)
        `CHECK("flush_restart_hi", t_hi, 32'd2)

        // Reset in cycle 5 aborts a DIVU
        run_op(2'b11, 32'd1000, 32'd3, 32'h0, 32'h0, 0, 0, 5, 40);
        `CHECK("rst_abort_done_count", t_done_cnt, 0)
        `CHECK("rst_abort_we_count", t_we_cnt, 0)
        `CHECK("rst_abort_stall_c6", t_stall[6], 1'b0)

        // MULT 6 * -7 with a second start in cycle 5
        run_op(2'b00, 32'd6, 32'hFFFF_FFF9, 32'd2, 32'd2, 0, 5, 0, 36);
        `CHECK("restart_done_count", t_done_cnt, RESTART_DONES)
        `CHECK("restart_hi", t_hi, 32'hFFFF_FFFF)
        `CHECK("restart_lo", t_lo, 32'hFFFF_FFD6)
        `CHECK("restart_done_cycle", t_done_cyc, MUL_LAT)

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`undef CHECK

`default_nettype wire
